// File: rtl/detect_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : detect_sweep_ctrl
// Purpose  : Sweeps codes 0..2**WIDTH-1 through an external detector and
//            records a per-code hit mask and a hit count.
//            Optional abort support is enabled by DETECT_SWEEP_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module detect_sweep_ctrl #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  f,
`ifdef DETECT_SWEEP_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic [WIDTH-1:0]      code,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH:0]        hit_count,
  output logic [(1<<WIDTH)-1:0] hit_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE);
  localparam logic [WIDTH-1:0] CODE_LAST   = '1;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      code_q, code_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WIDTH:0]        hit_count_q, hit_count_d;
  logic [(1<<WIDTH)-1:0] hit_mask_q, hit_mask_d;
  logic                  abort_req;

`ifdef DETECT_SWEEP_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_req = abort;

  always_comb begin
    aborted_d = (state_q == DRIVE) && abort;
  end

  always_ff @(posedge clk) begin
    if (reset) aborted_q <= 1'b0;
    else       aborted_q <= aborted_d;
  end

  assign aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    hit_count_d = hit_count_q;
    hit_mask_d  = hit_mask_q;
    case (state_q)
      IDLE: begin
        code_d = '0;
        if (start) begin
          state_d     = DRIVE;
          cnt_d       = '0;
          hit_count_d = '0;
          hit_mask_d  = '0;
        end
      end
      DRIVE: begin
        // Abort takes priority even over the final sample edge.
        if (abort_req) begin
          state_d = IDLE;
          code_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q != SETTLE_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          hit_mask_d[code_q] = f;
          hit_count_d        = hit_count_q + {{WIDTH{1'b0}}, f};
          cnt_d              = '0;
          if (code_q == CODE_LAST) state_d = DONE;
          else                     code_d  = code_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = '0;
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= '0;
      cnt_q       <= '0;
      hit_count_q <= '0;
      hit_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      hit_count_q <= hit_count_d;
      hit_mask_q  <= hit_mask_d;
    end
  end

  assign code      = code_q;
  assign busy      = (state_q == DRIVE);
  assign done      = (state_q == DONE);
  assign hit_count = hit_count_q;
  assign hit_mask  = hit_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_detect_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_detect_sweep_ctrl
// Purpose  : Self-checking bench for detect_sweep_ctrl; two instances
//            (SETTLE=0 and SETTLE=1) against a timeline-based sweep model.
// Revision : 1.0  initial release
// ============================================================================
module tb_detect_sweep_ctrl;

  localparam int W = 3;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   reset_v, start_v, f_v, rnd_v, busy_v, done_v;
  logic [1:0]   mode_v [2];
  logic [W-1:0] code_v [2];
  logic [W:0]   cnt_v  [2];
  logic [N-1:0] mask_v [2];
`ifdef DETECT_SWEEP_ABORT_EN
  logic [1:0]   abort_v, aborted_v;
`endif

  int errors = 0;
  int checks = 0;
  bit go = 1'b0;

  // Detector modes: 0 tied low, 1 tied high, 2 the 2-or-5 detector, 3 random.
  function automatic logic det(input logic [1:0] m, input logic [W-1:0] c, input logic r);
    case (m)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return (c == W'(2)) || (c == W'(5));
      default: return r;
    endcase
  endfunction

  assign f_v[0] = det(mode_v[0], code_v[0], rnd_v[0]);
  assign f_v[1] = det(mode_v[1], code_v[1], rnd_v[1]);

  detect_sweep_ctrl #(.WIDTH(W), .SETTLE(0)) u_s0 (
    .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .f(f_v[0]),
`ifdef DETECT_SWEEP_ABORT_EN
    .abort(abort_v[0]), .aborted(aborted_v[0]),
`endif
    .code(code_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .hit_count(cnt_v[0]), .hit_mask(mask_v[0])
  );

  detect_sweep_ctrl #(.WIDTH(W), .SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .f(f_v[1]),
`ifdef DETECT_SWEEP_ABORT_EN
    .abort(abort_v[1]), .aborted(aborted_v[1]),
`endif
    .code(code_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .hit_count(cnt_v[1]), .hit_mask(mask_v[1])
  );

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s actual=%0h required=%0h at %0t", k, name, act, exp, $time);
    end
  endtask

  // Model: instance k holds each code k+1 cycles. A sweep is tracked as the
  // number of edges elapsed since the accepting edge.
  bit           m_act [2];
  int           m_el  [2];
  logic [N-1:0] m_mask[2];
  int           m_cnt [2];
  bit           m_abd [2];

  function automatic int sweep_len(input int k);
    return N * (k + 1);
  endfunction

  function automatic int exp_code(input int k);
    if (!m_act[k])                return 0;
    if (m_el[k] < sweep_len(k))   return m_el[k] / (k + 1);
    return N - 1;
  endfunction

  function automatic bit abort_now(input int k);
`ifdef DETECT_SWEEP_ABORT_EN
    return abort_v[k];
`else
    return (k < 0);
`endif
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset_v[k]) begin
        m_act[k] = 0; m_el[k] = 0; m_mask[k] = '0; m_cnt[k] = 0; m_abd[k] = 0;
      end else begin
        m_abd[k] = 0;
        if (!m_act[k]) begin
          if (start_v[k]) begin
            m_act[k] = 1; m_el[k] = 0; m_mask[k] = '0; m_cnt[k] = 0;
          end
        end else if (m_el[k] == sweep_len(k)) begin
          m_act[k] = 0;
        end else if (abort_now(k)) begin
          m_act[k] = 0; m_abd[k] = 1;
        end else begin
          if ((m_el[k] + 1) % (k + 1) == 0) begin
            int  c;
            logic fm;
            c  = m_el[k] / (k + 1);
            fm = det(mode_v[k], W'(c), rnd_v[k]);
            m_mask[k][c] = fm;
            m_cnt[k] += int'(fm);
          end
          m_el[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      for (int k = 0; k < 2; k++) begin
        chk(k, "code", 32'(code_v[k]), 32'(exp_code(k)));
        chk(k, "busy", 32'(busy_v[k]), 32'(m_act[k] && m_el[k] < sweep_len(k)));
        chk(k, "done", 32'(done_v[k]), 32'(m_act[k] && m_el[k] == sweep_len(k)));
        chk(k, "hit_count", 32'(cnt_v[k]), 32'(m_cnt[k]));
        chk(k, "hit_mask", 32'(mask_v[k]), 32'(m_mask[k]));
`ifdef DETECT_SWEEP_ABORT_EN
        chk(k, "aborted", 32'(aborted_v[k]), 32'(m_abd[k]));
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, output int t, output int b);
    t = 0; b = 0;
    while (!done_v[k] && t < 200) begin
      if (busy_v[k]) b++;
      tick;
      t++;
    end
  endtask

  task automatic sweep(input int k, input logic [1:0] m, output int t, output int b);
    mode_v[k]  = m;
    start_v[k] = 1'b1;
    tick;
    start_v[k] = 1'b0;
    wait_done(k, t, b);
  endtask

  int t, b;

  initial begin
    reset_v = 2'b11; start_v = 2'b00; rnd_v = 2'b00;
    mode_v[0] = 2'd0; mode_v[1] = 2'd0;
`ifdef DETECT_SWEEP_ABORT_EN
    abort_v = 2'b00;
`endif
    tick;
    go = 1'b1;
    tick;
    reset_v = 2'b00;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_code", 32'(code_v[k]), 32'd0);
      chk(k, "rst_busy", 32'(busy_v[k]), 32'd0);
      chk(k, "rst_done", 32'(done_v[k]), 32'd0);
      chk(k, "rst_count", 32'(cnt_v[k]), 32'd0);
      chk(k, "rst_mask", 32'(mask_v[k]), 32'd0);
    end

    // 2/5 detector, SETTLE=1
    sweep(1, 2'd2, t, b);
    chk(1, "s1_latency", 32'(t), 32'd16);
    chk(1, "s1_busy_cycles", 32'(b), 32'd16);
    chk(1, "s1_mask_25", 32'(mask_v[1]), 32'h24);
    chk(1, "s1_count_25", 32'(cnt_v[1]), 32'd2);
    tick;

    // f tied high, SETTLE=0
    sweep(0, 2'd1, t, b);
    chk(0, "s0_latency", 32'(t), 32'd8);
    chk(0, "s0_mask_ones", 32'(mask_v[0]), 32'hFF);
    chk(0, "s0_count_ones", 32'(cnt_v[0]), 32'd8);
    tick;

    // Results cleared by a new start
    sweep(1, 2'd1, t, b);
    tick;
    sweep(1, 2'd0, t, b);
    chk(1, "zero_mask", 32'(mask_v[1]), 32'h00);
    chk(1, "zero_count", 32'(cnt_v[1]), 32'd0);
    tick;
    sweep(1, 2'd2, t, b);
    chk(1, "again_mask", 32'(mask_v[1]), 32'h24);
    chk(1, "again_count", 32'(cnt_v[1]), 32'd2);
    tick;

    // Start pulse in the 3rd DRIVE cycle is ignored
    mode_v[1] = 2'd2;
    start_v[1] = 1'b1; tick; start_v[1] = 1'b0;
    tick; tick;
    start_v[1] = 1'b1; tick; start_v[1] = 1'b0;
    wait_done(1, t, b);
    chk(1, "ignored_latency", 32'(t + 3), 32'd16);
    chk(1, "ignored_mask", 32'(mask_v[1]), 32'h24);
    tick;

    // Start held high: one IDLE cycle between sweeps
    start_v[1] = 1'b1; tick;
    wait_done(1, t, b);
    chk(1, "held_latency", 32'(t), 32'd16);
    tick;
    chk(1, "held_idle_busy", 32'(busy_v[1]), 32'd0);
    tick;
    chk(1, "held_restart_busy", 32'(busy_v[1]), 32'd1);
    start_v[1] = 1'b0;
    wait_done(1, t, b);
    tick;

    // Reset in the 5th DRIVE cycle
    mode_v[1] = 2'd1;
    start_v[1] = 1'b1; tick; start_v[1] = 1'b0;
    tick; tick; tick; tick;
    chk(1, "partial_mask", 32'(mask_v[1]), 32'h03);
    reset_v[1] = 1'b1; tick; reset_v[1] = 1'b0;
    chk(1, "midrst_code", 32'(code_v[1]), 32'd0);
    chk(1, "midrst_busy", 32'(busy_v[1]), 32'd0);
    chk(1, "midrst_done", 32'(done_v[1]), 32'd0);
    chk(1, "midrst_mask", 32'(mask_v[1]), 32'd0);
    chk(1, "midrst_count", 32'(cnt_v[1]), 32'd0);
    sweep(1, 2'd2, t, b);
    chk(1, "post_rst_mask", 32'(mask_v[1]), 32'h24);
    tick;

`ifdef DETECT_SWEEP_ABORT_EN
    mode_v[1] = 2'd2;
    start_v[1] = 1'b1; tick; start_v[1] = 1'b0;
    t = 0;
    while (code_v[1] != W'(4) && t < 100) begin tick; t++; end
    chk(1, "abort_wait_ok", 32'(t < 100), 32'd1);
    abort_v[1] = 1'b1; tick; abort_v[1] = 1'b0;
    chk(1, "abort_pulse", 32'(aborted_v[1]), 32'd1);
    chk(1, "abort_no_done", 32'(done_v[1]), 32'd0);
    chk(1, "abort_mask", 32'(mask_v[1]), 32'h04);
    chk(1, "abort_count", 32'(cnt_v[1]), 32'd1);
    tick;
    chk(1, "abort_one_cycle", 32'(aborted_v[1]), 32'd0);

    mode_v[1] = 2'd1;
    start_v[1] = 1'b1; tick; start_v[1] = 1'b0;
    t = 0;
    while (code_v[1] != W'(7) && t < 100) begin tick; t++; end
    tick;
    abort_v[1] = 1'b1; tick; abort_v[1] = 1'b0;
    chk(1, "final_abort_pulse", 32'(aborted_v[1]), 32'd1);
    chk(1, "final_abort_no_done", 32'(done_v[1]), 32'd0);
    chk(1, "final_abort_mask", 32'(mask_v[1]), 32'h7F);
    chk(1, "final_abort_count", 32'(cnt_v[1]), 32'd7);
    tick; tick;
`endif

    // Randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        start_v[k] = ($urandom % 4) == 0;
        reset_v[k] = ($urandom % 150) == 0;
        mode_v[k]  = 2'($urandom % 4);
        rnd_v[k]   = 1'($urandom);
`ifdef DETECT_SWEEP_ABORT_EN
        abort_v[k] = ($urandom % 40) == 0;
`endif
      end
      tick;
    end
    start_v = 2'b00; reset_v = 2'b00;
    tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
